// File: rtl/spi_slave_sync.sv
// SPI responder fully synchronous to clk: sck/cs_n/mosi are oversampled, edges are
// detected in the clk domain, and a one-entry TX holding buffer feeds the shifter.
module spi_slave_sync #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  localparam logic SCK_IDLE = (CPOL != 0);
  localparam int   CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_prev;
  logic                   cs_prev;

  logic sck_s;
  logic cs_s;
  logic mosi_s;
  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;
  logic cs_fall;

  state_t state_q;
  state_t state_d;

  logic              do_load;
  logic              do_shift;
  logic              do_sample;
  logic              clr_word;
  logic              accept;

  logic [CNT_W-1:0]  bit_cnt_q;
  logic              reload_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] hold_data_q;
  logic              hold_full_q;

  // Synchronisers plus one extra flop per edge-detected signal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= SCK_IDLE;
      cs_prev   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s       = sck_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign lead_edge   = (sck_s != SCK_IDLE) && (sck_prev == SCK_IDLE);
  assign trail_edge  = (sck_s == SCK_IDLE) && (sck_prev != SCK_IDLE);
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
  assign cs_fall     = !cs_s && cs_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // CPHA=0 preloads at the cs_n fall and reloads on the shift edge after a full word;
  // CPHA=1 loads on the first shift edge of every word.
  always_comb begin
    state_d   = state_q;
    do_load   = 1'b0;
    do_shift  = 1'b0;
    do_sample = 1'b0;
    clr_word  = 1'b0;
    case (state_q)
      IDLE: begin
        clr_word = 1'b1;
        if (cs_fall) begin
          state_d = ACTIVE;
          do_load = (CPHA == 0);
        end
      end
      ACTIVE: begin
        if (cs_s) begin
          state_d  = IDLE;
          clr_word = 1'b1;
        end else begin
          do_sample = sample_edge;
          if (shift_edge) begin
            if ((CPHA == 0) ? reload_q : (bit_cnt_q == '0)) begin
              do_load = 1'b1;
            end else begin
              do_shift = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept  = tx_valid && !hold_full_q;
  assign rx_next = {rx_shift_q[DATA_W-2:0], mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      reload_q    <= 1'b0;
      rx_shift_q  <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_shift_q  <= '0;
      tx_underrun <= 1'b0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (clr_word) begin
        bit_cnt_q <= '0;
        reload_q  <= 1'b0;
      end

      if (do_sample) begin
        rx_shift_q <= rx_next;
        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
          bit_cnt_q <= '0;
          rx_data   <= rx_next;
          rx_valid  <= 1'b1;
          reload_q  <= 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end

      if (do_load) begin
        reload_q <= 1'b0;
        if (hold_full_q) begin
          tx_shift_q <= hold_data_q;
        end else begin
          tx_shift_q  <= '0;
          tx_underrun <= 1'b1;
        end
      end else if (do_shift) begin
        tx_shift_q <= tx_shift_q << 1;
      end

      // accept only happens while empty, so a same-cycle load never sees the new word
      if (accept) begin
        hold_data_q <= tx_data;
        hold_full_q <= 1'b1;
      end else if (do_load) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  assign spi_miso    = tx_shift_q[DATA_W-1];
  assign spi_miso_oe = !cs_s;
  assign busy        = !cs_s;
  assign tx_ready    = !hold_full_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Scoreboarded bench for spi_slave_sync: a mode-0 instance and a mode-3 instance
// driven by bench-side SPI masters at f_sck = f_clk/16.
`timescale 1ns/1ps
module tb_spi_slave_sync;

  localparam int HALF = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sck_a = 1'b0, cs_a = 1'b1, mosi_a = 1'b0;
  logic       miso_a, oe_a, rdy_a, und_a, rxv_a, busy_a;
  logic [7:0] txd_a = 8'h00;
  logic       txv_a = 1'b0;
  logic [7:0] rxd_a;

  logic       sck_b = 1'b1, cs_b = 1'b1, mosi_b = 1'b0;
  logic       miso_b, oe_b, rdy_b, und_b, rxv_b, busy_b;
  logic [7:0] txd_b = 8'h00;
  logic       txv_b = 1'b0;
  logic [7:0] rxd_b;

  spi_slave_sync #(.DATA_W(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .spi_sck(sck_a), .spi_cs_n(cs_a), .spi_mosi(mosi_a),
    .spi_miso(miso_a), .spi_miso_oe(oe_a), .tx_data(txd_a), .tx_valid(txv_a),
    .tx_ready(rdy_a), .tx_underrun(und_a), .rx_data(rxd_a), .rx_valid(rxv_a), .busy(busy_a)
  );

  spi_slave_sync #(.DATA_W(8), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .spi_sck(sck_b), .spi_cs_n(cs_b), .spi_mosi(mosi_b),
    .spi_miso(miso_b), .spi_miso_oe(oe_b), .tx_data(txd_b), .tx_valid(txv_b),
    .tx_ready(rdy_b), .tx_underrun(und_b), .rx_data(rxd_b), .rx_valid(rxv_b), .busy(busy_b)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int und_cnt_a = 0, und_cnt_b = 0, rxv_cnt_a = 0;
  int samp_cyc_a = 0, samp_cyc_b = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: every rx_valid pops one expected word; latency is from the final sample edge at the pin
  always @(negedge clk) begin
    logic [7:0] e;
    if (und_a) und_cnt_a++;
    if (und_b) und_cnt_b++;
    if (rxv_a) begin
      rxv_cnt_a++;
      if (exp_a.size() == 0) begin
        total++; bad++;
        $display("FAIL rx_a_spurious: actual rx_valid with rx_data=0x%0h required no rx_valid", rxd_a);
      end else begin
        e = exp_a.pop_front();
        chk("rx_a_data", 32'(rxd_a), 32'(e));
        chk("rx_a_latency", 32'(cyc - samp_cyc_a), 32'd3);
      end
    end
    if (rxv_b) begin
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL rx_b_spurious: actual rx_valid with rx_data=0x%0h required no rx_valid", rxd_b);
      end else begin
        e = exp_b.pop_front();
        chk("rx_b_data", 32'(rxd_b), 32'(e));
        chk("rx_b_latency", 32'(cyc - samp_cyc_b), 32'd3);
      end
    end
  end

  task automatic tx_write(input bit sel, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (((sel ? rdy_b : rdy_a) == 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if ((sel ? rdy_b : rdy_a) == 1'b0) begin
      total++; bad++;
      $display("FAIL tx_write_timeout: actual tx_ready=0 required 1");
    end else begin
      if (sel) begin txd_b = d; txv_b = 1'b1; end
      else     begin txd_a = d; txv_a = 1'b1; end
      @(negedge clk);
      txv_a = 1'b0;
      txv_b = 1'b0;
    end
  endtask

  // Mode-0 master; und_mid is the underrun count taken just after the last sample edge
  task automatic xfer_a(input int nw, input logic [7:0] w0, input logic [7:0] w1,
                        output logic [7:0] r0, output logic [7:0] r1, output int und_mid);
    logic [7:0] tw[2];
    logic [7:0] rw[2];
    int u0;
    u0 = und_cnt_a;
    tw[0] = w0; tw[1] = w1;
    rw[0] = 8'h00; rw[1] = 8'h00;
    und_mid = 0;
    @(negedge clk);
    cs_a = 1'b0;
    for (int w = 0; w < nw; w++) begin
      for (int i = 7; i >= 0; i--) begin
        mosi_a = tw[w][i];
        clks(HALF);
        sck_a = 1'b1;
        samp_cyc_a = cyc;
        rw[w][i] = miso_a;
        clks(4);
        if (w == nw - 1 && i == 0) und_mid = und_cnt_a - u0;
        clks(HALF - 4);
        sck_a = 1'b0;
      end
    end
    clks(HALF);
    cs_a = 1'b1;
    clks(2 * HALF);
    r0 = rw[0];
    r1 = rw[1];
  endtask

  task automatic bits_a(input logic [7:0] w, input int nb);
    @(negedge clk);
    cs_a = 1'b0;
    for (int i = 7; i > 7 - nb; i--) begin
      mosi_a = w[i];
      clks(HALF);
      sck_a = 1'b1;
      clks(HALF);
      sck_a = 1'b0;
    end
  endtask

  task automatic xfer_b(input logic [7:0] w, output logic [7:0] r);
    r = 8'h00;
    @(negedge clk);
    cs_b = 1'b0;
    clks(HALF);
    for (int i = 7; i >= 0; i--) begin
      sck_b = 1'b0;
      mosi_b = w[i];
      clks(HALF);
      sck_b = 1'b1;
      samp_cyc_b = cyc;
      r[i] = miso_b;
      clks(HALF);
    end
    cs_b = 1'b1;
    clks(2 * HALF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual run still active required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r0, r1;
    int um, base;

    clks(2);
    chk("rst_miso_a", 32'(miso_a), 0);
    chk("rst_oe_a", 32'(oe_a), 0);
    chk("rst_ready_a", 32'(rdy_a), 1);
    chk("rst_underrun_a", 32'(und_a), 0);
    chk("rst_rx_data_a", 32'(rxd_a), 0);
    chk("rst_rx_valid_a", 32'(rxv_a), 0);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_miso_b", 32'(miso_b), 0);
    chk("rst_ready_b", 32'(rdy_b), 1);
    rst_n = 1'b1;
    clks(4);

    // preloaded word, single transfer
    tx_write(1'b0, 8'h3C);
    chk("t1_ready_full", 32'(rdy_a), 0);
    exp_a.push_back(8'hA5);
    xfer_a(1, 8'hA5, 8'h00, r0, r1, um);
    chk("t1_miso", 32'(r0), 32'h3C);
    chk("t1_no_underrun", 32'(um), 0);
    chk("t1_ready_after_load", 32'(rdy_a), 1);

    // back-to-back words, second tx word written mid word 1
    tx_write(1'b0, 8'h12);
    exp_a.push_back(8'h81);
    exp_a.push_back(8'h7E);
    fork
      xfer_a(2, 8'h81, 8'h7E, r0, r1, um);
      begin clks(40); tx_write(1'b0, 8'h34); end
    join
    chk("t2_miso_w0", 32'(r0), 32'h12);
    chk("t2_miso_w1", 32'(r1), 32'h34);
    chk("t2_no_underrun", 32'(um), 0);

    // empty holding register at the cs_n fall
    exp_a.push_back(8'hFF);
    xfer_a(1, 8'hFF, 8'h00, r0, r1, um);
    chk("t3_miso_zero", 32'(r0), 32'h00);
    chk("t3_underrun_once", 32'(um), 1);

    // abort after 5 sample edges, then a fresh word
    base = rxv_cnt_a;
    bits_a(8'h5A, 5);
    clks(HALF);
    cs_a = 1'b1;
    clks(2 * HALF);
    chk("t4_no_rx_valid", 32'(rxv_cnt_a - base), 0);
    chk("t4_rx_data_held", 32'(rxd_a), 32'hFF);
    chk("t4_idle_busy", 32'(busy_a), 0);
    exp_a.push_back(8'hC3);
    xfer_a(1, 8'hC3, 8'h00, r0, r1, um);
    chk("t4_miso_zero", 32'(r0), 32'h00);

    // mode-3 instance
    tx_write(1'b1, 8'h5A);
    base = und_cnt_b;
    exp_b.push_back(8'h96);
    xfer_b(8'h96, r0);
    chk("t5_miso", 32'(r0), 32'h5A);
    chk("t5_no_underrun", 32'(und_cnt_b - base), 0);
    chk("t5_ready", 32'(rdy_b), 1);

    // reset mid-word with a word waiting in holding
    bits_a(8'hA5, 4);
    tx_write(1'b0, 8'h77);
    chk("t6_holding_full", 32'(rdy_a), 0);
    chk("t6_busy_before", 32'(busy_a), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_miso", 32'(miso_a), 0);
    chk("t6_rst_oe", 32'(oe_a), 0);
    chk("t6_rst_ready", 32'(rdy_a), 1);
    chk("t6_rst_rx_data", 32'(rxd_a), 0);
    chk("t6_rst_busy", 32'(busy_a), 0);
    chk("t6_rst_underrun", 32'(und_a), 0);
    cs_a = 1'b1;
    sck_a = 1'b0;
    mosi_a = 1'b0;
    clks(2);
    rst_n = 1'b1;
    clks(2 * HALF);
    chk("t6_idle_busy", 32'(busy_a), 0);
    exp_a.push_back(8'hA5);
    xfer_a(1, 8'hA5, 8'h00, r0, r1, um);
    chk("t6_miso_holding_lost", 32'(r0), 32'h00);

    for (int n = 0; n < 50 && (exp_a.size() != 0 || exp_b.size() != 0); n++) clks(1);
    chk("drain_a", 32'(exp_a.size()), 0);
    chk("drain_b", 32'(exp_b.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
